// File: rtl/lsu.sv
// lsu -- load/store unit placed after the execute stage.
//
// Runs one data-bus transaction for the current load or store. The request
// goes out on a valid/ready channel and the reply comes back on a response
// channel. Load data is aligned and sign- or zero-extended for GPR
// write-back. The core is stalled while the transaction is in flight.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   load, store         current instruction is a load / a store
//   mem_op[7:0]         [2:0] = funct3 (B/H/W/BU/HU); [7:3] unused
//   addr, wdata         effective address, store data (rs2)
//   stall               freeze fetch/decode/GPR write
//   done                one-cycle completion pulse
//   rdata               extended load result, valid while done=1
//   err_misalign        one-cycle pulse with done: misaligned or reserved op
//   err_bus             one-cycle pulse with done: transaction timed out
//   bus_valid/ready     request handshake
//   bus_addr/we/wstrb/wdata  request fields (word address, lane-replicated)
//   bus_rvalid/rdata    response (write ack or read word)
//
// Parameter TIMEOUT (1..65535): number of REQ+RESP cycles allowed before
// the transaction is abandoned with a bus error.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [7:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misalign,
  output logic        err_bus,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  f3_reg;
  logic        we_reg;
  // One bit wider than TIMEOUT needs: after a handshake on the timeout
  // cycle the count can reach TIMEOUT+1 before the response arrives.
  logic [16:0] cnt_reg;
  logic [31:0] rdata_reg;
  logic        err_mis_reg;
  logic        err_bus_reg;

  logic        start;
  logic        mis_in;
  logic        start_aligned;
  logic [16:0] cnt_now;
  logic        timed_out;
  logic [2:0]  size_bytes;
  logic [3:0]  lane_en;
  logic [31:0] wdata_rep;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic        unused_mem_op;

  assign unused_mem_op = ^mem_op[7:3];

  // Only a single op type starts a transaction; load&store together is dropped.
  assign start = (state_reg == IDLE) && (load ^ store);

  // Misalignment / reserved-encoding check on the live inputs.
  always_comb begin
    mis_in = 1'b0;
    if (store) begin
      if (mem_op[2] || (mem_op[1:0] == 2'b11)) mis_in = 1'b1;
      else if (mem_op[1:0] == 2'b01)           mis_in = addr[0];
      else if (mem_op[1:0] == 2'b10)           mis_in = |addr[1:0];
    end else begin
      case (mem_op[2:0])
        3'b000, 3'b100: mis_in = 1'b0;
        3'b001, 3'b101: mis_in = addr[0];
        3'b010:         mis_in = |addr[1:0];
        default:        mis_in = 1'b1;
      endcase
    end
  end

  assign start_aligned = start && !mis_in;

  // The current REQ/RESP cycle counts towards the limit.
  assign cnt_now   = cnt_reg + 17'd1;
  assign timed_out = (cnt_now >= 17'(TIMEOUT));

  // Access size in bytes from the captured funct3.
  always_comb begin
    case (f3_reg[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  end

  // Per-lane strobe and replicated write data. A lane is enabled when it
  // lies inside [offset, offset+size). Only aligned accesses reach REQ, so
  // the window never runs past lane 3.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_en[gi] = ({1'b0, addr_reg[1:0]} <= 3'(gi)) &&
                           (3'(gi) < ({1'b0, addr_reg[1:0]} + size_bytes));
      assign wdata_rep[8*gi +: 8] =
          (f3_reg[1:0] == 2'b00) ? wdata_reg[7:0] :
          (f3_reg[1:0] == 2'b01) ? wdata_reg[8*(gi%2) +: 8] :
                                   wdata_reg[8*gi +: 8];
    end
  endgenerate

  // Load alignment: move the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    load_shifted = bus_rdata >> {addr_reg[1:0], 3'b000};
    case (f3_reg)
      3'b000:  load_ext = {{24{load_shifted[7]}},  load_shifted[7:0]};
      3'b100:  load_ext = {24'd0,                  load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_ext = {16'd0,                  load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Next-state logic. Handshake / response take priority over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = mis_in ? DONE : REQ;
      REQ: begin
        if (bus_ready)      state_next = RESP;
        else if (timed_out) state_next = DONE;
      end
      RESP: begin
        // rvalid is never sampled in REQ, which drops any rvalid that
        // arrives in the handshake cycle.
        if (bus_rvalid || timed_out) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      f3_reg      <= 3'd0;
      we_reg      <= 1'b0;
      cnt_reg     <= 17'd0;
      rdata_reg   <= 32'd0;
      err_mis_reg <= 1'b0;
      err_bus_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg    <= addr;
            wdata_reg   <= wdata;
            f3_reg      <= mem_op[2:0];
            we_reg      <= store;
            cnt_reg     <= 17'd0;
            err_mis_reg <= mis_in;
            err_bus_reg <= 1'b0;
            rdata_reg   <= 32'd0;
          end
        end
        REQ: begin
          cnt_reg <= cnt_now;
          if (!bus_ready && timed_out) err_bus_reg <= 1'b1;
        end
        RESP: begin
          cnt_reg <= cnt_now;
          if (bus_rvalid)     rdata_reg   <= we_reg ? 32'd0 : load_ext;
          else if (timed_out) err_bus_reg <= 1'b1;
        end
        DONE: begin
          rdata_reg   <= 32'd0;
          err_mis_reg <= 1'b0;
          err_bus_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign stall        = start_aligned || (state_reg == REQ) || (state_reg == RESP);
  assign done         = (state_reg == DONE);
  assign rdata        = rdata_reg;
  assign err_misalign = (state_reg == DONE) && err_mis_reg;
  assign err_bus      = (state_reg == DONE) && err_bus_reg;

  // Request fields are driven only while the request is valid.
  assign bus_valid = (state_reg == REQ);
  assign bus_addr  = bus_valid ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign bus_we    = bus_valid && we_reg;
  assign bus_wstrb = (bus_valid && we_reg) ? lane_en : 4'b0000;
  assign bus_wdata = (bus_valid && we_reg) ? wdata_rep : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a table of directed transactions with hand-computed
// expectations, a reset-in-flight sequence, then randomized transactions
// checked against a cycle-count / byte-lane reference model.
module tb_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, store;
  logic [7:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, done, err_misalign, err_bus;
  logic [31:0] rdata;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .err_misalign(err_misalign), .err_bus(err_bus),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_bad  = 0;
  int txn_no = 0;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rw;
    int          d1, d2;      // ready wait cycles in REQ, rvalid wait cycles in RESP
    bit          junk;        // assert bogus rvalid during REQ
    int          exp_k;       // cycle after start holding done (0: no transaction)
    logic        exp_mis, exp_berr;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_bwd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (txn %0d): got 0x%08h expected 0x%08h", name, txn_no, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic ld, logic st, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] rw, int d1, int d2, bit junk,
                               int exp_k, logic mis, logic berr, logic [31:0] rd,
                               logic [3:0] strb, logic [31:0] bwd);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.rw = rw;
    v.d1 = d1; v.d2 = d2; v.junk = junk; v.exp_k = exp_k;
    v.exp_mis = mis; v.exp_berr = berr; v.exp_rdata = rd;
    v.exp_strb = strb; v.exp_bwd = bwd;
    return v;
  endfunction

  // Reference model: fills in expectations from the access rules and the
  // cycle position of ready/rvalid relative to the timeout limit.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int size, off, k_h, k_r, t_resp;
    bit mis;
    logic [31:0] sh;
    off = int'(v.a[1:0]);
    case (v.f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      default: size = 4;
    endcase
    if (v.ld) mis = (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7) || (off % size != 0);
    else      mis = v.f3[2] || (v.f3 == 3'd3) || (off % size != 0);
    r.exp_mis = mis; r.exp_berr = 1'b0; r.exp_rdata = 32'd0;
    r.exp_strb = 4'd0; r.exp_bwd = 32'd0;
    if (!(v.ld ^ v.st)) begin
      r.exp_k = 0; r.exp_mis = 1'b0;
      return r;
    end
    if (mis) begin
      r.exp_k = 1;
      return r;
    end
    if (v.st) begin
      for (int i = 0; i < 4; i++) begin
        r.exp_strb[i] = (i >= off) && (i < off + size);
        r.exp_bwd[8*i +: 8] = v.wd[8*(i % size) +: 8];
      end
    end
    k_h = v.d1 + 1;
    if (k_h > TMO) begin
      r.exp_k = TMO + 1; r.exp_berr = 1'b1;
      return r;
    end
    k_r    = k_h + 1 + v.d2;
    t_resp = (TMO > k_h + 1) ? TMO : k_h + 1;
    if (k_r > t_resp) begin
      r.exp_k = t_resp + 1; r.exp_berr = 1'b1;
      return r;
    end
    r.exp_k = k_r + 1;
    if (v.ld) begin
      sh = v.rw >> (8 * off);
      case (v.f3)
        3'd0:    r.exp_rdata = $signed(sh[7:0]);
        3'd1:    r.exp_rdata = $signed(sh[15:0]);
        3'd4:    r.exp_rdata = sh[7:0];
        3'd5:    r.exp_rdata = sh[15:0];
        default: r.exp_rdata = sh;
      endcase
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with
  // the DUT back in IDLE.
  task automatic run_txn(input vec_t v);
    int  k_h, k_r;
    bit  aligned;
    txn_no++;
    k_h = v.d1 + 1;
    k_r = k_h + 1 + v.d2;
    aligned = (v.ld ^ v.st) && !v.exp_mis;
    load = v.ld; store = v.st; mem_op = {5'($urandom), v.f3};
    addr = v.a; wdata = v.wd; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    chk("start_stall", 32'(stall), 32'(aligned));
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_rdata", rdata, 32'd0);
    chk("idle_valid", 32'(bus_valid), 32'd0);
    if (v.exp_k == 0) begin
      @(posedge clk); #1;
      load = 1'b0; store = 1'b0;
      @(negedge clk);
      chk("ignored_done", 32'(done), 32'd0);
      chk("ignored_valid", 32'(bus_valid), 32'd0);
      @(posedge clk); #1;
      $display("txn %0d: ld=%0d st=%0d ignored", txn_no, v.ld, v.st);
      return;
    end
    for (int k = 1; k <= v.exp_k; k++) begin
      @(posedge clk); #1;
      // Inputs outside IDLE must be ignored, so they are scrambled here.
      load = 1'($urandom); store = 1'($urandom); mem_op = 8'($urandom);
      addr = $urandom; wdata = $urandom;
      bus_ready  = (k == k_h);
      bus_rvalid = (k == k_r) || (v.junk && k <= k_h);
      bus_rdata  = (k == k_r) ? v.rw : $urandom;
      @(negedge clk);
      if (k < v.exp_k) begin
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_done", 32'(done), 32'd0);
        chk("bus_valid", 32'(bus_valid), 32'(k <= k_h));
        if (k <= k_h) begin
          chk("bus_addr", bus_addr, {v.a[31:2], 2'b00});
          chk("bus_we", 32'(bus_we), 32'(v.st));
          chk("bus_wstrb", 32'(bus_wstrb), 32'(v.exp_strb));
          chk("bus_wdata", bus_wdata, v.exp_bwd);
        end
      end else begin
        chk("done", 32'(done), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_valid", 32'(bus_valid), 32'd0);
        chk("err_misalign", 32'(err_misalign), 32'(v.exp_mis));
        chk("err_bus", 32'(err_bus), 32'(v.exp_berr));
        chk("rdata", rdata, v.exp_rdata);
      end
    end
    @(posedge clk); #1;
    load = 1'b0; store = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    $display("txn %0d: ld=%0d st=%0d f3=%0d addr=%08h done@%0d mis=%0d berr=%0d rdata=%08h",
             txn_no, v.ld, v.st, v.f3, v.a, v.exp_k, v.exp_mis, v.exp_berr, v.exp_rdata);
  endtask

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            ld st f3    addr          wdata         rword         d1 d2 jk k  mis berr rdata         strb     bwd
    tbl[0]  = mkv(1, 0, 3'd2, 32'h100,      32'h0,        32'hDEADBEEF, 0, 0, 0, 3, 0, 0, 32'hDEADBEEF, 4'b0000, 32'h0);
    tbl[1]  = mkv(1, 0, 3'd0, 32'h103,      32'h0,        32'h80123456, 0, 0, 0, 3, 0, 0, 32'hFFFFFF80, 4'b0000, 32'h0);
    tbl[2]  = mkv(1, 0, 3'd4, 32'h103,      32'h0,        32'h80123456, 0, 0, 1, 3, 0, 0, 32'h00000080, 4'b0000, 32'h0);
    tbl[3]  = mkv(1, 0, 3'd1, 32'h102,      32'h0,        32'h80015678, 0, 0, 0, 3, 0, 0, 32'hFFFF8001, 4'b0000, 32'h0);
    tbl[4]  = mkv(0, 1, 3'd1, 32'h202,      32'h1234ABCD, 32'h0,        3, 0, 0, 6, 0, 0, 32'h0,        4'b1100, 32'hABCDABCD);
    tbl[5]  = mkv(1, 0, 3'd2, 32'h101,      32'h0,        32'h0,        9, 9, 0, 1, 1, 0, 32'h0,        4'b0000, 32'h0);
    tbl[6]  = mkv(0, 1, 3'd1, 32'h3,        32'h55AA55AA, 32'h0,        9, 9, 0, 1, 1, 0, 32'h0,        4'b0000, 32'h0);
    tbl[7]  = mkv(1, 0, 3'd2, 32'h40,       32'h0,        32'h0,        10, 0, 0, 5, 0, 1, 32'h0,       4'b0000, 32'h0);
    tbl[8]  = mkv(1, 0, 3'd2, 32'h44,       32'h0,        32'h13572468, 3, 0, 1, 6, 0, 0, 32'h13572468, 4'b0000, 32'h0);
    tbl[9]  = mkv(1, 1, 3'd2, 32'h48,       32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        4'b0000, 32'h0);
    tbl[10] = mkv(0, 1, 3'd0, 32'h41,       32'h000000EF, 32'h0,        1, 1, 0, 5, 0, 0, 32'h0,        4'b0010, 32'hEFEFEFEF);
    tbl[11] = mkv(1, 0, 3'd5, 32'h2,        32'h0,        32'hFFFE0000, 0, 1, 0, 4, 0, 0, 32'h0000FFFE, 4'b0000, 32'h0);
    tbl[12] = mkv(1, 0, 3'd2, 32'h8,        32'h0,        32'h0,        0, 5, 0, 5, 0, 1, 32'h0,        4'b0000, 32'h0);

    rst = 1'b1; load = 1'b0; store = 1'b0; mem_op = 8'h0; addr = 32'h0; wdata = 32'h0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_errs", 32'({err_misalign, err_bus}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tbl[i]);

    // Reset while waiting for the response: abandon silently.
    txn_no++;
    load = 1'b1; mem_op = 8'h02; addr = 32'h20;
    @(posedge clk); #1;
    load = 1'b0; bus_ready = 1'b1;               // REQ, handshake
    @(posedge clk); #1;
    bus_ready = 1'b0; rst = 1'b1;                // RESP
    @(negedge clk);
    chk("resp_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstmid_valid", 32'(bus_valid), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("rstmid_done2", 32'(done), 32'd0);
    $display("txn %0d: reset during RESP", txn_no);
    @(posedge clk); #1;
    run_txn(model(mkv(0, 1, 3'd2, 32'h10, 32'h87654321, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      v = mkv(0, 0, 3'd0, $urandom, $urandom, $urandom,
              $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom),
              0, 0, 0, 0, 0, 0);
      v.a[31:12] = 20'h0;
      if (sel < 9) begin
        v.ld = 1'b1; v.f3 = 3'($urandom);
      end else if (sel < 18) begin
        v.st = 1'b1;
        case ($urandom_range(0, 5))
          0: v.f3 = 3'd0; 1: v.f3 = 3'd1; 2: v.f3 = 3'd2;
          3: v.f3 = 3'd4; 4: v.f3 = 3'd5; default: v.f3 = 3'd6;
        endcase
      end else begin
        v.ld = (sel == 18); v.st = (sel == 18); v.f3 = 3'd2;
      end
      run_txn(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
